// File: rtl/pll_seq_pkg.sv
// Shared types and helpers for the PLL lock sequencer: state encoding,
// the loss-counter ceiling, and the width rule for the shared cycle counter.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PLL_RST,
        WAIT_LOCK,
        SETTLE,
        RUN,
        FAIL
    } seq_state_t;

    localparam int LOCK_LOSS_MAX = 255;

    // The counter only ever has to hold (longest phase - 1), so clog2 of the
    // longest phase is enough; never let it collapse to zero bits.
    function automatic int cntWidth(input int rstCycles, input int timeout, input int settle);
        int longest;
        longest = rstCycles;
        if (timeout > longest) longest = timeout;
        if (settle > longest) longest = settle;
        return (longest < 2) ? 1 : $clog2(longest);
    endfunction

endpackage

// File: rtl/pll_lock_sequencer_if.sv
// Control and status bundle between the PLL lock sequencer and its environment.
// The slave side is the sequencer; the master side drives enable and sees the PLL flag.
interface pll_lock_sequencer_if;

    logic       enable;
    logic       pll_lock;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic       fail;
    logic [3:0] retry_count;
    logic [7:0] lock_loss_count;

    modport master (
        output enable,
        output pll_lock,
        input  pll_rst,
        input  sys_rst,
        input  ready,
        input  fail,
        input  retry_count,
        input  lock_loss_count
    );

    modport slave (
        input  enable,
        input  pll_lock,
        output pll_rst,
        output sys_rst,
        output ready,
        output fail,
        output retry_count,
        output lock_loss_count
    );

endinterface

// File: rtl/pll_lock_sequencer_sync_ff.sv
// N-stage single-bit synchroniser for bringing the asynchronous PLL lock flag
// into the reference clock domain. Clears to 0 so lock is never assumed at reset.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] stage_q;

    // Shift the raw flag through the flop chain; only the last stage is used.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_q <= '0;
        end else begin
            stage_q <= {stage_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL lock sequencer: pulses the PLL reset, waits for a stable synchronised
// lock, then releases the downstream reset. Lock loss re-sequences the PLL and
// repeated lock timeouts park the block in FAIL until enable is dropped.
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int LOCK_SYNC_STAGES = 2,
    parameter int PLL_RST_CYCLES   = 16,
    parameter int LOCK_TIMEOUT     = 25000,
    parameter int SETTLE_CYCLES    = 256,
    parameter int MAX_RETRIES      = 7
) (
    input  logic clk,
    input  logic reset,
    pll_lock_sequencer_if.slave bus
);

    localparam int SYNC_N = (LOCK_SYNC_STAGES < 2) ? 2 : LOCK_SYNC_STAGES;
    localparam int CW     = cntWidth(PLL_RST_CYCLES, LOCK_TIMEOUT, SETTLE_CYCLES);

    localparam logic [CW-1:0] PRST_LAST    = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE_CYCLES - 1);
    localparam logic [3:0]    RETRY_LIMIT  = 4'(MAX_RETRIES);
    localparam logic [7:0]    LOSS_SAT     = 8'(LOCK_LOSS_MAX);

    seq_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    retry_q, retry_d;
    logic [7:0]    lossCnt_q, lossCnt_d;
    logic          pllRst_q, sysRst_q, ready_q, fail_q;
    logic          lockSync;
    logic          counting;
    logic [3:0]    retryInc;

    sync_ff #(
        .STAGES (SYNC_N)
    ) u_lockSync (
        .clk   (clk),
        .reset (reset),
        .d_i   (bus.pll_lock),
        .q_o   (lockSync)
    );

    // Next-state, counter and status decisions; a dropped enable overrides everything
    // except the lock-loss tally, which still records a loss seen in the same cycle.
    always_comb begin
        state_d   = state_q;
        retry_d   = retry_q;
        lossCnt_d = lossCnt_q;
        retryInc  = retry_q + 4'd1;
        counting  = (state_q == PLL_RST) || (state_q == WAIT_LOCK) || (state_q == SETTLE);

        case (state_q)
            IDLE: begin
                if (bus.enable) begin
                    retry_d = 4'd0;
                    state_d = PLL_RST;
                end
            end
            PLL_RST: begin
                if (cnt_q == PRST_LAST) begin
                    state_d = WAIT_LOCK;
                end
            end
            WAIT_LOCK: begin
                if (lockSync) begin
                    state_d = SETTLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    retry_d = retryInc;
                    state_d = (retryInc == RETRY_LIMIT) ? FAIL : PLL_RST;
                end
            end
            SETTLE: begin
                if (!lockSync) begin
                    state_d = WAIT_LOCK;
                end else if (cnt_q == SETTLE_LAST) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!lockSync) begin
                    if (lossCnt_q != LOSS_SAT) begin
                        lossCnt_d = lossCnt_q + 8'd1;
                    end
                    retry_d = 4'd0;
                    state_d = PLL_RST;
                end
            end
            FAIL: begin
                state_d = FAIL;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (!bus.enable) begin
            state_d = IDLE;
            retry_d = retry_q;
        end

        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (counting) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State, counters and all outputs registered together so outputs track the state exactly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            retry_q   <= 4'd0;
            lossCnt_q <= 8'd0;
            pllRst_q  <= 1'b1;
            sysRst_q  <= 1'b1;
            ready_q   <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            lossCnt_q <= lossCnt_d;
            pllRst_q  <= (state_d == IDLE) || (state_d == PLL_RST) || (state_d == FAIL);
            sysRst_q  <= (state_d != RUN);
            ready_q   <= (state_d == RUN);
            fail_q    <= (state_d == FAIL);
        end
    end

    assign bus.pll_rst         = pllRst_q;
    assign bus.sys_rst         = sysRst_q;
    assign bus.ready           = ready_q;
    assign bus.fail            = fail_q;
    assign bus.retry_count     = retry_q;
    assign bus.lock_loss_count = lossCnt_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Testbench for the PLL lock sequencer with small timing parameters: a
// timeline-based reference model checked every cycle, directed scenarios with
// hand-computed latencies, and a randomized enable/lock phase.
module tb_pll_lock_sequencer;

    localparam int SYNC    = 2;
    localparam int PRST    = 4;
    localparam int TIMEOUT = 20;
    localparam int SETTLEN = 8;
    localparam int RETRIES = 3;

    localparam int P_IDLE = 0, P_PRST = 1, P_WAIT = 2, P_SETTLE = 3, P_RUN = 4, P_FAIL = 5;
    localparam int S_PLLRST = 0, S_SYSRST = 1, S_READY = 2, S_FAIL = 3;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   n;

    int mPhase = P_IDLE;
    int mEntry = 0;
    int mCycle = 0;
    int mRetry = 0;
    int mLoss  = 0;
    bit syncPipe[$];

    pll_lock_sequencer_if dutIf ();

    pll_lock_sequencer #(
        .LOCK_SYNC_STAGES (SYNC),
        .PLL_RST_CYCLES   (PRST),
        .LOCK_TIMEOUT     (TIMEOUT),
        .SETTLE_CYCLES    (SETTLEN),
        .MAX_RETRIES      (RETRIES)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dutIf.slave)
    );

    // Free-running reference clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [15:0] outVec();
        return {dutIf.pll_rst, dutIf.sys_rst, dutIf.ready, dutIf.fail,
                dutIf.retry_count, dutIf.lock_loss_count};
    endfunction

    function automatic logic [15:0] expVec();
        logic pr, sr, rd, fl;
        pr = (mPhase == P_IDLE) || (mPhase == P_PRST) || (mPhase == P_FAIL);
        sr = (mPhase != P_RUN);
        rd = (mPhase == P_RUN);
        fl = (mPhase == P_FAIL);
        return {pr, sr, rd, fl, 4'(mRetry), 8'(mLoss)};
    endfunction

    function automatic logic sigSel(input int which);
        case (which)
            S_PLLRST: return dutIf.pll_rst;
            S_SYSRST: return dutIf.sys_rst;
            S_READY:  return dutIf.ready;
            default:  return dutIf.fail;
        endcase
    endfunction

    // Reference model: time spent in the current phase and a delay line for the
    // synchronised lock flag; outputs follow from the phase reached.
    task automatic modelStep();
        bit lockS;
        int elapsed;
        int nextPhase;
        if (reset) begin
            mPhase = P_IDLE; mEntry = 0; mCycle = 0; mRetry = 0; mLoss = 0;
            syncPipe = {};
            for (int i = 0; i < SYNC; i++) syncPipe.push_back(1'b0);
            return;
        end
        if (syncPipe.size() != SYNC) begin
            syncPipe = {};
            for (int i = 0; i < SYNC; i++) syncPipe.push_back(1'b0);
        end
        lockS = syncPipe.pop_front();
        syncPipe.push_back(dutIf.pll_lock);
        elapsed = mCycle - mEntry;
        nextPhase = mPhase;
        if (!dutIf.enable) begin
            if (mPhase == P_RUN && !lockS && mLoss < 255) mLoss++;
            nextPhase = P_IDLE;
        end else begin
            case (mPhase)
                P_IDLE: begin mRetry = 0; nextPhase = P_PRST; end
                P_PRST: if (elapsed + 1 == PRST) nextPhase = P_WAIT;
                P_WAIT: begin
                    if (lockS) nextPhase = P_SETTLE;
                    else if (elapsed + 1 == TIMEOUT) begin
                        mRetry++;
                        nextPhase = (mRetry == RETRIES) ? P_FAIL : P_PRST;
                    end
                end
                P_SETTLE: begin
                    if (!lockS) nextPhase = P_WAIT;
                    else if (elapsed + 1 == SETTLEN) nextPhase = P_RUN;
                end
                P_RUN: begin
                    if (!lockS) begin
                        if (mLoss < 255) mLoss++;
                        mRetry = 0;
                        nextPhase = P_PRST;
                    end
                end
                default: nextPhase = mPhase;
            endcase
        end
        if (nextPhase != mPhase) mEntry = mCycle + 1;
        mPhase = nextPhase;
        mCycle++;
    endtask

    // Advance the model on every clock edge and on reset assertion.
    initial forever begin
        @(posedge clk or posedge reset);
        modelStep();
    end

    // Compare all DUT outputs with the model mid-cycle.
    initial forever begin
        @(negedge clk);
        checkOutput("cycle_outputs", 32'(outVec()), 32'(expVec()));
    end

    // Hang guard.
    initial begin
        #900000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step(input int cyc);
        repeat (cyc) begin
            @(posedge clk);
            #3;
        end
    endtask

    task automatic applyStimulus(input logic en, input logic lock, input int cyc);
        dutIf.enable   = en;
        dutIf.pll_lock = lock;
        step(cyc);
    endtask

    task automatic stepUntil(input int which, input logic val, input int bound, output int cnt);
        cnt = 0;
        while (sigSel(which) !== val && cnt < bound) begin
            step(1);
            cnt++;
        end
    endtask

    initial begin
        reset = 1'b1;
        dutIf.enable = 1'b0;
        dutIf.pll_lock = 1'b0;
        step(3);
        checkOutput("reset_values", 32'(outVec()), 32'h0000_C000);
        reset = 1'b0;
        step(2);

        $display("[TB] nominal bring-up");
        dutIf.enable = 1'b1;
        stepUntil(S_PLLRST, 1'b0, 50, n);
        checkOutput("nominal_pllrst_fall", n, 5);
        applyStimulus(1'b1, 1'b0, 10);
        dutIf.pll_lock = 1'b1;
        stepUntil(S_SYSRST, 1'b0, 50, n);
        checkOutput("nominal_release_latency", n, 11);
        checkOutput("nominal_ready_retry", {dutIf.ready, dutIf.retry_count}, 5'b10000);

        $display("[TB] lock loss in run");
        dutIf.pll_lock = 1'b0;
        stepUntil(S_SYSRST, 1'b1, 50, n);
        checkOutput("lockloss_sysrst_delay", n, 3);
        checkOutput("lockloss_count", dutIf.lock_loss_count, 1);
        dutIf.pll_lock = 1'b1;
        stepUntil(S_PLLRST, 1'b0, 50, n);
        checkOutput("relock_pllrst_pulse", n, 4);
        stepUntil(S_READY, 1'b1, 100, n);
        checkOutput("relock_ready", dutIf.ready, 1);

        $display("[TB] lock loss together with enable drop");
        dutIf.pll_lock = 1'b0;
        step(2);
        dutIf.enable = 1'b0;
        step(1);
        checkOutput("loss_and_disable", {dutIf.pll_rst, dutIf.sys_rst, dutIf.ready, dutIf.lock_loss_count}, {3'b110, 8'd2});

        $display("[TB] repeated lock loss");
        applyStimulus(1'b1, 1'b1, 0);
        stepUntil(S_READY, 1'b1, 100, n);
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'b1, 1'b0, 3);
            dutIf.pll_lock = 1'b1;
            stepUntil(S_READY, 1'b1, 100, n);
        end
        checkOutput("loss_saturates", dutIf.lock_loss_count, 255);

        $display("[TB] enable priority");
        applyStimulus(1'b0, 1'b1, 1);
        checkOutput("disable_in_run", {dutIf.pll_rst, dutIf.sys_rst, dutIf.ready}, 3'b110);
        applyStimulus(1'b1, 1'b1, 8);
        checkOutput("in_settle", {dutIf.pll_rst, dutIf.sys_rst}, 2'b01);
        applyStimulus(1'b0, 1'b1, 1);
        checkOutput("disable_in_settle", {dutIf.pll_rst, dutIf.sys_rst, dutIf.ready}, 3'b110);
        applyStimulus(1'b1, 1'b1, 2);
        applyStimulus(1'b0, 1'b1, 1);
        checkOutput("disable_in_pllrst", {dutIf.pll_rst, dutIf.sys_rst}, 2'b11);
        dutIf.enable = 1'b1;
        stepUntil(S_PLLRST, 1'b0, 50, n);
        checkOutput("restart_full_pulse", n, 5);
        stepUntil(S_READY, 1'b1, 100, n);

        $display("[TB] glitchy settle");
        applyStimulus(1'b0, 1'b0, 3);
        dutIf.enable = 1'b1;
        stepUntil(S_PLLRST, 1'b0, 50, n);
        checkOutput("glitch_pllrst_fall", n, 5);
        applyStimulus(1'b1, 1'b1, 5);
        checkOutput("glitch_hold", dutIf.sys_rst, 1);
        applyStimulus(1'b1, 1'b0, 1);
        dutIf.pll_lock = 1'b1;
        stepUntil(S_SYSRST, 1'b0, 50, n);
        checkOutput("glitch_release", n, 11);

        $display("[TB] lock on the timeout cycle");
        applyStimulus(1'b0, 1'b0, 3);
        dutIf.enable = 1'b1;
        stepUntil(S_PLLRST, 1'b0, 50, n);
        step(17);
        dutIf.pll_lock = 1'b1;
        stepUntil(S_SYSRST, 1'b0, 50, n);
        checkOutput("timeout_edge_release", n, 11);
        checkOutput("timeout_edge_retry", dutIf.retry_count, 0);

        $display("[TB] randomized enable/lock");
        dutIf.enable = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 2) dutIf.enable = ~dutIf.enable;
            if ($urandom_range(0, 99) < 8) dutIf.pll_lock = ~dutIf.pll_lock;
            step(1);
        end

        $display("[TB] timeout to fail");
        applyStimulus(1'b0, 1'b0, 3);
        dutIf.enable = 1'b1;
        stepUntil(S_FAIL, 1'b1, 200, n);
        checkOutput("fail_latency", n, 73);
        checkOutput("fail_outputs", {dutIf.pll_rst, dutIf.sys_rst, dutIf.ready, dutIf.fail, dutIf.retry_count}, 8'b1101_0011);
        applyStimulus(1'b0, 1'b0, 1);
        checkOutput("fail_exit", dutIf.fail, 0);

        $display("[TB] async reset in run");
        applyStimulus(1'b1, 1'b1, 0);
        stepUntil(S_READY, 1'b1, 100, n);
        checkOutput("pre_reset_ready", dutIf.ready, 1);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("async_reset", 32'(outVec()), 32'h0000_C000);
        step(2);
        reset = 1'b0;
        step(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
- Sequences the 25 MHz→112.5 MHz PLL used by the RDS transmitter.
- Runs entirely in the 25 MHz reference domain. Drives PLL reset, watches the PLL lock flag, and releases the downstream 112.5 MHz logic reset only after lock has been stable.
- On lock-loss it re-sequences the PLL. After repeated lock timeouts it latches a fail status.

Parameters:
- LOCK_SYNC_STAGES, 2: flip-flop stages on pll_lock (minimum 2).
- PLL_RST_CYCLES, 16: pll_rst pulse length in clk cycles (≥1).
- LOCK_TIMEOUT, 25000: cycles allowed in WAIT_LOCK before a retry (1 ms at 25 MHz).
- SETTLE_CYCLES, 256: consecutive cycles synced lock must stay high before release.
- MAX_RETRIES, 7: number of timeouts that causes FAIL (1..15).

Ports:
- clk  in  1  25 MHz reference clock; single clock domain.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  sequencer run request; synchronous to clk.
- pll_lock  in  1  PLL lock flag; asynchronous to clk.
- pll_rst  out  1  PLL reset, active-high.
- sys_rst  out  1  downstream logic reset, active-high.
- ready  out  1  high only in RUN.
- fail  out  1  high only in FAIL.
- retry_count  out  4  timeouts since the last IDLE exit.
- lock_loss_count  out  8  lock losses seen in RUN; saturates at 255.

Behaviour:
- All outputs are registered. While reset is asserted: state=IDLE, pll_rst=1, sys_rst=1, ready=0, fail=0, retry_count=0, lock_loss_count=0.
- lock_s = pll_lock after LOCK_SYNC_STAGES flops. All decisions use lock_s only.
- One cycle counter cnt is shared by all states. It clears on every state entry.
- IDLE: pll_rst=1, sys_rst=1.
  - enable=1 → clear retry_count, go to PLL_RST.
- PLL_RST: pll_rst=1.
  - After exactly PLL_RST_CYCLES cycles in the state → WAIT_LOCK.
- WAIT_LOCK: pll_rst=0, sys_rst=1.
  - lock_s=1 → SETTLE.
  - Else if cnt reaches LOCK_TIMEOUT-1: retry_count+1. If the new value equals MAX_RETRIES → FAIL, else → PLL_RST.
- SETTLE: pll_rst=0, sys_rst=1.
  - lock_s=0 → WAIT_LOCK. The timeout restarts from 0.
  - After SETTLE_CYCLES consecutive cycles with lock_s=1 → RUN.
- RUN: sys_rst=0, ready=1.
  - lock_s=0 → next cycle sys_rst=1, ready=0, lock_loss_count+1 (saturating), retry_count cleared, go to PLL_RST.
- FAIL: pll_rst=1, sys_rst=1, fail=1. Leaves only on enable=0 (→ IDLE) or on reset.
- enable=0 in any state → IDLE on the next cycle. This takes priority over all other transitions. lock_loss_count is kept.
- Simultaneous events in RUN: lock_s=0 with enable=0 → IDLE; lock_loss_count still increments.
- Simultaneous events in WAIT_LOCK: lock_s=1 on the timeout cycle → SETTLE; no retry is counted.
- Reset mid-operation: immediate asynchronous return to the reset values above. pll_rst and sys_rst assert without waiting for a clock edge.
- Width rules:
  - cnt width = clog2 of the maximum of PLL_RST_CYCLES, LOCK_TIMEOUT, SETTLE_CYCLES.
  - Compares are unsigned.
  - retry_count never exceeds MAX_RETRIES.
- Release latency from a clean pll_lock rise (lock already high before WAIT_LOCK): LOCK_SYNC_STAGES + 1 + SETTLE_CYCLES cycles to sys_rst=0.

Decomposition:
- Package pll_seq_pkg:
  - state enum: IDLE, PLL_RST, WAIT_LOCK, SETTLE, RUN, FAIL.
  - width function for cnt.
  - LOCK_LOSS_MAX = 255.
- Sub-module sync_ff: parameterised N-stage bit synchroniser with async reset to 0, used for pll_lock.
- The rest is a single FSM plus counters in pll_lock_sequencer.

Test Plan (PLL_RST_CYCLES=4, LOCK_TIMEOUT=20, SETTLE_CYCLES=8, MAX_RETRIES=3, LOCK_SYNC_STAGES=2):
- Nominal: reset, enable=1, pll_lock rises 10 cycles after pll_rst falls → pll_rst high exactly 4 cycles; sys_rst falls 11 cycles after the pll_lock rise; ready=1; retry_count=0.
- Timeout/fail: enable=1, pll_lock held 0 → three pll_rst pulses of 4 cycles, each followed by 20 WAIT_LOCK cycles; fail=1 with retry_count=3, pll_rst=1, sys_rst=1; then enable=0 → IDLE, fail=0 next cycle.
- Glitchy settle: lock high for 5 cycles, low for 1, then high → sys_rst stays 1; release occurs 8 cycles after the second SETTLE entry.
- Lock loss in RUN: drop pll_lock for 3 cycles → sys_rst=1 three cycles after the drop; lock_loss_count=1; a new 4-cycle pll_rst pulse; re-release after relock. Repeat 300 times → count=255.
- Enable priority: deassert enable in SETTLE and again in PLL_RST → IDLE the next cycle each time, with pll_rst=1 and sys_rst=1.
- Async reset mid-RUN: assert reset between clk edges → pll_rst=1, sys_rst=1, ready=0 immediately; both counters read 0.
